// File: rtl/debug_pkg.sv
// Shared command bytes and controller state encoding, also used by the debug tx unit.
package debug_pkg;

    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_RST  = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_PRST = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CONT = 3'd1,
        OP_STEP = 3'd2,
        OP_HALT = 3'd3,
        OP_RST  = 3'd4
    } op_e;

    // Unrecognised bytes and bytes without a valid strobe both decode to OP_NONE.
    function automatic op_e decode_cmd(input logic valid, input logic [7:0] data);
        op_e op;
        op = OP_NONE;
        if (valid) begin
            case (data)
                CMD_CONT: op = OP_CONT;
                CMD_STEP: op = OP_STEP;
                CMD_HALT: op = OP_HALT;
                CMD_RST:  op = OP_RST;
                default:  op = OP_NONE;
            endcase
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/debug_run_controller_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !(&count_q)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/debug_run_controller.sv
// Sequences pipeline run/step/halt/soft-reset from debug-UART command bytes and
// requests a state dump after every step or halt.
module debug_run_controller
    import debug_pkg::*;
#(
    parameter int CYCLE_W    = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         inDato,
    input  logic               inDatoValid,
    input  logic               inHalt,
    input  logic               inDumpDone,
    output logic               outPipeEnable,
    output logic               outPipeReset,
    output logic               outDumpReq,
    output logic               outProgramDone,
    output logic [CYCLE_W-1:0] outCycleCount
);

    localparam int PRST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PRST_W-1:0] PRST_LAST = PRST_W'(RST_CYCLES - 1);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [PRST_W-1:0] prst_cnt_q, prst_cnt_d;
    logic              enable_q, dump_req_q, pipe_rst_q;
    logic              cnt_clr_s;
    op_e               op_s;

    // Next-state, sticky program-done flag and soft-reset length counter.
    always_comb begin
        op_s       = decode_cmd(inDatoValid, inDato);
        state_d    = state_q;
        done_d     = done_q;
        prst_cnt_d = prst_cnt_q;
        cnt_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (op_s)
                    OP_CONT: begin
                        if (!done_q) state_d = ST_RUN;
                        else         state_d = ST_IDLE;
                    end
                    OP_STEP: begin
                        if (!done_q) state_d = ST_STEP;
                        else         state_d = ST_IDLE;
                    end
                    OP_RST: begin
                        state_d    = ST_PRST;
                        done_d     = 1'b0;
                        cnt_clr_s  = 1'b1;
                        prst_cnt_d = '0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_RUN: begin
                // A halt instruction takes priority and also marks the program finished.
                if (inHalt) begin
                    state_d = ST_DUMP;
                    done_d  = 1'b1;
                end else if (op_s == OP_HALT) begin
                    state_d = ST_DUMP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_DUMP;
                if (inHalt) done_d = 1'b1;
                else        done_d = done_q;
            end
            ST_DUMP: begin
                if (inDumpDone) state_d = ST_IDLE;
                else            state_d = ST_DUMP;
            end
            ST_PRST: begin
                if (prst_cnt_q == PRST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_PRST;
                    prst_cnt_d = prst_cnt_q + PRST_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, flags and outputs; outputs are decoded from the next state so they
    // line up with the state register without a combinational output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            prst_cnt_q <= '0;
            enable_q   <= 1'b0;
            dump_req_q <= 1'b0;
            pipe_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            prst_cnt_q <= prst_cnt_d;
            enable_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
            dump_req_q <= (state_d == ST_DUMP);
            pipe_rst_q <= (state_d == ST_PRST);
        end
    end

    sat_counter #(
        .W(CYCLE_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (enable_q),
        .clr_i   (cnt_clr_s),
        .count_o (outCycleCount)
    );

    assign outPipeEnable  = enable_q;
    assign outDumpReq     = dump_req_q;
    assign outPipeReset   = pipe_rst_q;
    assign outProgramDone = done_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Randomised scoreboard bench for debug_run_controller with a behavioural model.
module tb_debug_run_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  inDato;
    logic        inDatoValid, inHalt, inDumpDone;
    logic        en16, prst16, dreq16, done16;
    logic [15:0] cnt16;
    logic        en4, prst4, dreq4, done4;
    logic [3:0]  cnt4;

    typedef struct {
        bit en;
        bit dreq;
        bit prst;
        bit pdone;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: what the pipeline is doing, as independent facts.
    bit m_run, m_step, m_dump, m_done;
    int m_prst_left, m_cnt;

    always #5 clk = ~clk;

    debug_run_controller dut (
        .clk(clk), .reset(reset), .inDato(inDato), .inDatoValid(inDatoValid),
        .inHalt(inHalt), .inDumpDone(inDumpDone), .outPipeEnable(en16),
        .outPipeReset(prst16), .outDumpReq(dreq16), .outProgramDone(done16),
        .outCycleCount(cnt16)
    );

    debug_run_controller #(.CYCLE_W(4)) dut4 (
        .clk(clk), .reset(reset), .inDato(inDato), .inDatoValid(inDatoValid),
        .inHalt(inHalt), .inDumpDone(inDumpDone), .outPipeEnable(en4),
        .outPipeReset(prst4), .outDumpReq(dreq4), .outProgramDone(done4),
        .outCycleCount(cnt4)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_step = 0; m_dump = 0; m_done = 0; m_prst_left = 0; m_cnt = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit v, input logic [7:0] b, input bit h, input bit d);
        if (m_run || m_step) m_cnt++;
        if (m_prst_left > 0) begin
            m_prst_left--;
        end else if (m_dump) begin
            if (d) m_dump = 0;
        end else if (m_step) begin
            m_step = 0;
            m_dump = 1;
            if (h) m_done = 1;
        end else if (m_run) begin
            if (h) begin
                m_run = 0; m_dump = 1; m_done = 1;
            end else if (v && b == 8'h68) begin
                m_run = 0; m_dump = 1;
            end
        end else if (v) begin
            if (b == 8'h72) begin
                m_prst_left = 4; m_done = 0; m_cnt = 0;
            end else if (b == 8'h63 && !m_done) begin
                m_run = 1;
            end else if (b == 8'h73 && !m_done) begin
                m_step = 1;
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit h, input bit d);
        exp_t e;
        @(negedge clk);
        inDatoValid = v; inDato = b; inHalt = h; inDumpDone = d;
        model_step(v, b, h, d);
        e.en = m_run | m_step;
        e.dreq = m_dump;
        e.prst = (m_prst_left > 0);
        e.pdone = m_done;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_enable", en16, 0);
        chk("arst_dumpreq", dreq16, 0);
        chk("arst_pipereset", prst16, 0);
        chk("arst_progdone", done16, 0);
        chk("arst_count", cnt16, 0);
        q.delete();
        model_clear();
        inDatoValid = 1'b0; inHalt = 1'b0; inDumpDone = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (!reset && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("enable", en16, mon_e.en);
            chk("dumpreq", dreq16, mon_e.dreq);
            chk("pipereset", prst16, mon_e.prst);
            chk("progdone", done16, mon_e.pdone);
            chk("count16", cnt16, (mon_e.cnt > 65535) ? 65535 : mon_e.cnt);
            chk("enable4", en4, mon_e.en);
            chk("count4", cnt4, (mon_e.cnt > 15) ? 15 : mon_e.cnt);
        end
    end

    initial begin
        logic [7:0] b;
        bit v, h, d;
        reset = 1'b1; inDato = 8'h00; inDatoValid = 1'b0; inHalt = 1'b0; inDumpDone = 1'b0;
        model_clear();
        #12;
        chk("reset_enable", en16, 0);
        chk("reset_dumpreq", dreq16, 0);
        chk("reset_pipereset", prst16, 0);
        chk("reset_progdone", done16, 0);
        chk("reset_count", cnt16, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single step, then dump handshake.
        cycle(1'b1, 8'h73, 1'b0, 1'b0); idle(3); cycle(1'b0, 8'h00, 1'b0, 1'b1); idle(1);
        // Continuous run stopped by halt command.
        cycle(1'b1, 8'h63, 1'b0, 1'b0); idle(10); cycle(1'b1, 8'h68, 1'b0, 1'b0);
        idle(2); cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Run into a halt instruction; later run/step must be ignored.
        cycle(1'b1, 8'h63, 1'b0, 1'b0); idle(3); cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2); cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h63, 1'b0, 1'b0); idle(2); cycle(1'b1, 8'h73, 1'b0, 1'b0); idle(2);
        // Soft reset clears done/count, then stepping works again.
        cycle(1'b1, 8'h72, 1'b0, 1'b0); idle(6);
        cycle(1'b1, 8'h73, 1'b0, 1'b0); idle(2); cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Long run saturates the 4-bit counter.
        cycle(1'b1, 8'h63, 1'b0, 1'b0); idle(20); cycle(1'b1, 8'h68, 1'b0, 1'b0);
        idle(1); cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Unknown byte in IDLE, step command during DUMP, stray dump-done in IDLE.
        cycle(1'b1, 8'h41, 1'b0, 1'b0); cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h73, 1'b0, 1'b0); idle(1); cycle(1'b1, 8'h73, 1'b0, 1'b0);
        idle(1); cycle(1'b0, 8'h00, 1'b0, 1'b1); idle(1);
        // Async reset while running.
        cycle(1'b1, 8'h63, 1'b0, 1'b0); idle(3);
        async_reset_check();

        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: b = 8'h63;
                1: b = 8'h73;
                2: b = 8'h68;
                3: b = 8'h72;
                4: b = 8'h41;
                5: b = 8'h63;
                default: b = 8'($urandom_range(0, 255));
            endcase
            h = ($urandom_range(0, 15) == 0);
            d = m_dump ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle(v, b, h, d);
            if ($urandom_range(0, 499) == 0) async_reset_check();
        end

        idle(1);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
